div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 divider for the M-extension DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of the execute-stage operand-select muxes, which supply dividend and divisor.
- Runs as a multi-cycle side unit: the pipeline stalls on busy and writes back result when done pulses.
- Decodes divide-by-zero and signed-overflow operands up front and finishes them early.

Parameters:
- WIDTH, 32, operand/result width in bits (RTL and checks are written for 32).
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new division; sampled only while busy=0.
- flush  input  1  abort any in-flight operation (pipeline kill).
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- dividend  input  WIDTH  rs1 value from operand mux.
- divisor  input  WIDTH  rs2 value from operand mux.
- tag_in  input  TAG_W  destination register index.
- busy  output  1  operation in progress; start ignored.
- done  output  1  one-cycle pulse; result/tag_out valid.
- result  output  WIDTH  quotient or remainder.
- tag_out  output  TAG_W  tag of the completed operation.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, tag_out=0, counter=0. rst overrides everything, including mid-operation; no done is produced for an op that rst kills.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 and flush=0 while in IDLE or DONE, in cycle T. op, operands and tag are latched at the T edge. Signed ops (DIV/REM) latch absolute values, plus quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
- Divide by zero (divisor==0): go straight to DONE. Quotient = all ones; remainder = dividend unmodified. done at T+1.
- Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): go straight to DONE. Quotient = 0x80000000; remainder = 0. done at T+1.
- Normal path:
  - CALC runs 32 cycles (T+1..T+32), counter 31 down to 0.
  - Each cycle does a restoring step: shift {rem,quot} left 1, trial subtract divisor from the 33-bit partial remainder, keep it if non-negative, set the quotient LSB accordingly.
  - FIX at T+33 applies two's-complement negation per the latched signs and selects quotient or remainder by op[1].
  - DONE at T+34.
- In DONE: done=1 for exactly one cycle. Next state is IDLE, or a new accept if start=1.
- busy=1 in CALC and FIX only, so it is 0 in IDLE and DONE.
- result and tag_out update only on entry to DONE and hold until the next DONE. They are never altered by flush.
- start while busy=1 is ignored, not queued.
- flush=1 in CALC or FIX: next state IDLE, busy drops the following cycle, no done.
- flush=1 in DONE: done is still driven that cycle (already registered), and any start that cycle is ignored.
- start and flush in the same cycle: flush wins and the start is dropped.
- Unsigned ops treat operands as full 32-bit magnitudes; 0xFFFFFFFF/1 must not overflow the partial remainder.

Test Plan:
- DIV 100/7, tag 3, start at T → busy T+1..T+33; done=1 only at T+34; result=0x0000000E, tag_out=3.
- REM -100 (0xFFFFFF9C) by 7 → 0xFFFFFFFE at T+34. DIV same operands → 0xFFFFFFF2.
- DIVU 5/0 → done at T+1, result=0xFFFFFFFF, busy never 1. REMU 5/0 → result=0x00000005.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1. REM same operands → 0x00000000. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF at T+34.
- Start DIVU 50/5, then pulse start (different operands) at T+5 → ignored. Then flush at T+10 → no done; busy=0 from T+11; result keeps its previous value. A new start at T+12 completes correctly.
- rst=1 at T+20 of an active op → all outputs 0 next cycle, no done. Back-to-back: start asserted during the DONE cycle is accepted, and its done arrives 34 cycles later.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete in a single cycle.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              selr_q, selr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [TAG_W-1:0]  tago_q, tago_d;

  logic              sgn, a_neg, b_neg;
  logic              div0, ovf, accept;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    shift, diff;
  logic              ge;
  logic [WIDTH-1:0]  q_fix, r_fix;

  assign sgn    = ~op[0];
  assign a_neg  = sgn & dividend[WIDTH-1];
  assign b_neg  = sgn & divisor[WIDTH-1];
  assign a_abs  = a_neg ? -dividend : dividend;
  assign b_abs  = b_neg ? -divisor : divisor;
  assign div0   = (divisor == '0);
  assign ovf    = sgn
                & (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                & (&divisor);
  assign accept = start & ~flush
                & ((state_q == IDLE) | (state_q == DONE));

  // 33-bit trial subtract keeps full-magnitude unsigned operands safe
  assign shift = {rem_q, quot_q[WIDTH-1]};
  assign diff  = shift - {1'b0, dvsr_q};
  assign ge    = ~diff[WIDTH];
  assign q_fix = negq_q ? -quot_q : quot_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    selr_d  = selr_q;
    tag_d   = tag_q;
    res_d   = res_q;
    tago_d  = tago_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (div0) begin
            state_d = DONE;
            res_d   = op[1] ? dividend : '1;
            tago_d  = tag_in;
          end else if (ovf) begin
            state_d = DONE;
            res_d   = op[1] ? '0
                    : {1'b1, {(WIDTH-1){1'b0}}};
            tago_d  = tag_in;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH - 1);
            rem_d   = '0;
            quot_d  = a_abs;
            dvsr_d  = b_abs;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            selr_d  = op[1];
            tag_d   = tag_in;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d  = ge ? diff[WIDTH-1:0] : shift[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ge};
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          res_d   = selr_q ? r_fix : q_fix;
          tago_d  = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      selr_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      tago_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      selr_q  <= selr_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      tago_q  <= tago_d;
    end
  end

  assign busy    = (state_q == CALC) | (state_q == FIX);
  assign done    = (state_q == DONE);
  assign result  = res_q;
  assign tag_out = tago_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, monitor
// compares result, tag and completion cycle on every done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [4:0]  tag_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  div_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .op(op), .dividend(dividend), .divisor(divisor),
    .tag_in(tag_in), .busy(busy), .done(done),
    .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  localparam logic [1:0] DIV = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cyc %0d)",
                 cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("result", result, x.res);
        chk("tag_out", {27'd0, tag_out}, {27'd0, x.tag});
        chk("done_cycle", cyc, x.cyc);
      end
    end
  end

  task automatic start_op(input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] t,
                          input logic [31:0] e,
                          input int lat,
                          input bit push,
                          output int t0);
    @(posedge clk); #1;
    op = o; dividend = a; divisor = b;
    tag_in = t; start = 1'b1;
    t0 = cyc;
    if (push) begin
      sb.push_back('{e, t, t0 + lat});
      last_res = e;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_busy(input int t0, input int lat);
    while (cyc <= t0 + lat) begin
      @(negedge clk);
      chk("busy", {31'd0, busy},
          {31'd0, (cyc > t0) && (cyc < t0 + lat)});
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[$] = '{
    '{DIV,  32'd100,        32'd7,          32'h0000000E, 34},
    '{REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE, 34},
    '{DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 34},
    '{DIVU, 32'd5,          32'd0,          32'hFFFFFFFF, 1},
    '{REMU, 32'd5,          32'd0,          32'h00000005, 1},
    '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1},
    '{REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000, 1},
    '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 34},
    '{REMU, 32'hFFFFFFFF,   32'h10,         32'h0000000F, 34},
    '{DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 34},
    '{REM,  32'd7,          32'hFFFFFFFE,   32'h00000001, 34},
    '{DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 34},
    '{REM,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF, 34},
    '{DIV,  32'h80000000,   32'd2,          32'hC0000000, 34}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; dividend = '0; divisor = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {27'd0, tag_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].o, vecs[i].a, vecs[i].b, 5'(i + 3),
               vecs[i].e, vecs[i].lat, 1'b1, t0);
      check_busy(t0, vecs[i].lat);
      wait_empty();
    end

    // ignored start while busy, then flush mid-CALC
    start_op(DIVU, 32'd50, 32'd5, 5'd1, 32'd10, 34, 1'b0, t0);
    wait_to(t0 + 5);
    op = DIV; dividend = 32'd9; divisor = 32'd0;
    tag_in = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ign_start_busy", {31'd0, busy}, 32'd1);
    wait_to(t0 + 10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", result, last_res);
    start_op(DIVU, 32'd50, 32'd5, 5'd11, 32'd10, 34, 1'b1, t0);
    check_busy(t0, 34);
    wait_empty();

    // reset kills an active op
    start_op(DIV, 32'd1000, 32'd3, 5'd12, 32'd333, 34, 1'b0, t0);
    wait_to(t0 + 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_tag", {27'd0, tag_out}, 32'd0);
    repeat (40) @(posedge clk);

    // start and flush together: flush wins
    @(posedge clk); #1;
    op = DIVU; dividend = 32'd9; divisor = 32'd3;
    tag_in = 5'd15; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);

    // back-to-back: second start issued in the DONE cycle
    start_op(REMU, 32'd1000, 32'd7, 5'd13, 32'd6, 34, 1'b1, ta);
    wait_to(ta + 33);
    start_op(DIVU, 32'd1000, 32'd7, 5'd14, 32'h8E, 34, 1'b1, tb);
    chk("b2b_start_cycle", tb, ta + 34);
    check_busy(tb, 34);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
